// File: rtl/de1_io_pkg.sv
// Shared constants and sizing helper for the DE1-SoC input conditioning slice.
package de1_io_pkg;

  localparam int unsigned CLK_HZ           = 50_000_000;
  localparam int unsigned DEF_TICK_CYCLES  = CLK_HZ / 1000;
  localparam int unsigned DEF_STABLE_TICKS = 10;

  // Bits needed to hold values 0..max_value; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_value);
    if (max_value < 1) begin
      return 1;
    end
    return $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One input bit: 2-FF synchroniser, tick-driven debouncer and registered edge pulses.
module debounce_bit
  import de1_io_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic clk_clk,
  input  logic reset_reset_n,
  input  logic raw,
  input  logic sample_tick,
  input  logic en_pulses,
  input  logic init_level,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = cnt_width(STABLE_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic          meta_q;
  logic          sync_q;
  logic          stable_q;
  logic [CW-1:0] cnt_q;
  logic          rise_q;
  logic          fall_q;
  logic          sync_lvl;

  // init_level is the inactive raw level, so XOR also yields the active-high view.
  assign sync_lvl = sync_q ^ init_level;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      meta_q   <= init_level;
      sync_q   <= init_level;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      meta_q <= raw;
      sync_q <= meta_q;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (sample_tick) begin
        if (sync_lvl == stable_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
          stable_q <= sync_lvl;
          cnt_q    <= '0;
          rise_q   <= en_pulses & sync_lvl;
          fall_q   <= en_pulses & ~sync_lvl;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign level = stable_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/de1_input_conditioner.sv
// Debounces DE1-SoC KEY/SW pins into clean levels and pulses.
// Define INPUT_EDGE_CAPTURE_EN to add sticky key edge capture with an irq output.
module de1_input_conditioner
  import de1_io_pkg::*;
#(
  parameter int unsigned N_KEYS         = 4,
  parameter int unsigned N_SW           = 10,
  parameter int unsigned TICK_CYCLES    = DEF_TICK_CYCLES,
  parameter int unsigned STABLE_TICKS   = DEF_STABLE_TICKS,
  parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [N_KEYS-1:0] key_raw,
  input  logic [N_SW-1:0]   sw_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_SW-1:0]   sw_level,
  output logic [N_SW-1:0]   sw_changed,
  output logic              init_done
`ifdef INPUT_EDGE_CAPTURE_EN
  ,
  input  logic [N_KEYS-1:0] edge_clear,
  output logic [N_KEYS-1:0] edge_capture,
  output logic              irq
`endif
);

  localparam int unsigned PW = cnt_width(TICK_CYCLES - 1);
  localparam int unsigned IW = cnt_width(STABLE_TICKS);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [IW-1:0] INIT_LAST = IW'(STABLE_TICKS - 1);

  logic [PW-1:0] presc_q;
  logic [IW-1:0] init_cnt_q;
  logic          init_done_q;
  logic          sample_tick;

  assign sample_tick = (presc_q == TICK_LAST);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      presc_q     <= '0;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      presc_q <= sample_tick ? '0 : presc_q + 1'b1;
      if (sample_tick && !init_done_q) begin
        if (init_cnt_q == INIT_LAST) begin
          init_done_q <= 1'b1;
        end else begin
          init_cnt_q <= init_cnt_q + 1'b1;
        end
      end
    end
  end

  assign init_done = init_done_q;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_db (
      .clk_clk      (clk_clk),
      .reset_reset_n(reset_reset_n),
      .raw          (key_raw[i]),
      .sample_tick  (sample_tick),
      .en_pulses    (init_done_q),
      .init_level   (KEY_ACTIVE_LOW),
      .level        (key_level[i]),
      .rise         (key_press[i]),
      .fall         (key_release[i])
    );
  end

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    logic sw_rise;
    logic sw_fall;

    debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_db (
      .clk_clk      (clk_clk),
      .reset_reset_n(reset_reset_n),
      .raw          (sw_raw[i]),
      .sample_tick  (sample_tick),
      .en_pulses    (init_done_q),
      .init_level   (1'b0),
      .level        (sw_level[i]),
      .rise         (sw_rise),
      .fall         (sw_fall)
    );

    assign sw_changed[i] = sw_rise | sw_fall;
  end

`ifdef INPUT_EDGE_CAPTURE_EN
  logic [N_KEYS-1:0] capture_q;

  // Set has priority over a same-cycle write-one-to-clear.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      capture_q <= '0;
    end else begin
      capture_q <= (capture_q & ~edge_clear) | key_press;
    end
  end

  assign edge_capture = capture_q;
  assign irq          = |capture_q;
`endif

endmodule

// File: tb/tb_de1_input_conditioner.sv
// Scoreboard bench: expected pulse events are queued at stimulus time and matched by a monitor.
module tb_de1_input_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_raw;
  logic [9:0] sw_raw;
  logic [3:0] key_level, key_press, key_release;
  logic [9:0] sw_level, sw_changed;
  logic       init_done;
`ifdef INPUT_EDGE_CAPTURE_EN
  logic [3:0] edge_clear;
  logic [3:0] edge_capture;
  logic       irq;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [3:0] kp;
    logic [3:0] kr;
    logic [9:0] sc;
    int         lo;
    int         hi;
  } exp_t;

  exp_t exp_q[$];

  de1_input_conditioner #(
    .N_KEYS        (4),
    .N_SW          (10),
    .TICK_CYCLES   (4),
    .STABLE_TICKS  (3),
    .KEY_ACTIVE_LOW(1'b1)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .key_raw      (key_raw),
    .sw_raw       (sw_raw),
    .key_level    (key_level),
    .key_press    (key_press),
    .key_release  (key_release),
    .sw_level     (sw_level),
    .sw_changed   (sw_changed),
    .init_done    (init_done)
`ifdef INPUT_EDGE_CAPTURE_EN
    ,
    .edge_clear   (edge_clear),
    .edge_capture (edge_capture),
    .irq          (irq)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raw edge driven now: level flips after 2 sync edges plus 9..12 more edges.
  task automatic expect_ev(input logic [3:0] kp, input logic [3:0] kr, input logic [9:0] sc);
    exp_t e;
    e.kp = kp;
    e.kr = kr;
    e.sc = sc;
    e.lo = cyc + 11;
    e.hi = cyc + 14;
    exp_q.push_back(e);
  endtask

  task automatic wait_init(input int t0);
    int seen;
    seen = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (init_done) begin
        seen = cyc - t0;
        break;
      end
    end
    check("init_cycle", seen, 12);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && (key_press | key_release | sw_changed) != '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {14'd0, key_press, key_release, sw_changed}, 0);
      end else begin
        e = exp_q.pop_front();
        check("ev_key_press", key_press, e.kp);
        check("ev_key_release", key_release, e.kr);
        check("ev_sw_changed", sw_changed, e.sc);
        check("ev_latency_window", (cyc >= e.lo && cyc <= e.hi), 1);
      end
    end
  end

  initial begin
    int found;
    #200000;
    $display("FAIL watchdog_timeout cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int found;
    rst_n   = 1'b0;
    key_raw = 4'hF;
    sw_raw  = 10'h000;
`ifdef INPUT_EDGE_CAPTURE_EN
    edge_clear = 4'h0;
`endif
    step(3);
    check("rst_key_level", key_level, 0);
    check("rst_key_press", key_press, 0);
    check("rst_key_release", key_release, 0);
    check("rst_sw_level", sw_level, 0);
    check("rst_sw_changed", sw_changed, 0);
    check("rst_init_done", init_done, 0);

    rst_n = 1'b1;
    t0 = cyc;
    wait_init(t0);
    check("init_key_level", key_level, 0);
    check("init_sw_level", sw_level, 0);
    step(1);

    key_raw[0] = 1'b0;
    expect_ev(4'h1, 4'h0, 10'h000);
    step(20);
    check("press_level", key_level, 4'h1);

    key_raw[1] = 1'b0;
    step(7);
    key_raw[1] = 1'b1;
    step(20);
    check("glitch_level", key_level[1], 0);

    key_raw[2] = 1'b0;
    expect_ev(4'h4, 4'h0, 10'h000);
    step(20);
    check("press2_level", key_level, 4'h5);

    key_raw[2] = 1'b1;
    sw_raw[3]  = 1'b1;
    expect_ev(4'h0, 4'h4, 10'h008);
    step(20);
    check("simul_key_level", key_level, 4'h1);
    check("simul_sw_level", sw_level, 10'h008);

    key_raw[0] = 1'b1;
    expect_ev(4'h0, 4'h1, 10'h000);
    step(20);
    check("release_level", key_level, 4'h0);

    sw_raw[3] = 1'b0;
    expect_ev(4'h0, 4'h0, 10'h008);
    step(20);
    check("sw_off_level", sw_level, 10'h000);

`ifdef INPUT_EDGE_CAPTURE_EN
    check("cap_idle", edge_capture, 4'h0);
    key_raw[3] = 1'b0;
    expect_ev(4'h8, 4'h0, 10'h000);
    step(20);
    check("cap_set", edge_capture, 4'h8);
    check("cap_irq", irq, 1);

    key_raw[3] = 1'b1;
    expect_ev(4'h0, 4'h8, 10'h000);
    step(20);
    check("cap_after_release", edge_capture, 4'h8);

    key_raw[3] = 1'b0;
    expect_ev(4'h8, 4'h0, 10'h000);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (key_press[3]) begin
        found = 1;
        break;
      end
    end
    check("cap_press2_seen", found, 1);
    edge_clear = 4'h8;
    @(posedge clk);
    #1;
    edge_clear = 4'h0;
    check("cap_set_wins", edge_capture, 4'h8);
    step(2);
    edge_clear = 4'h8;
    @(posedge clk);
    #1;
    edge_clear = 4'h0;
    check("cap_clear", edge_capture, 4'h0);
    check("cap_irq_clear", irq, 0);

    key_raw[3] = 1'b1;
    expect_ev(4'h0, 4'h8, 10'h000);
    step(20);
`endif
    check("queue_drained_a", exp_q.size(), 0);

    // Second reset lands mid-debounce with switches already on.
    key_raw[1] = 1'b0;
    step(5);
    rst_n = 1'b0;
    #1;
    check("midrst_init_done", init_done, 0);
    check("midrst_key_level", key_level, 0);
`ifdef INPUT_EDGE_CAPTURE_EN
    check("midrst_capture", edge_capture, 4'h0);
`endif
    key_raw = 4'hF;
    sw_raw  = 10'h201;
    step(3);
    rst_n = 1'b1;
    t0 = cyc;
    wait_init(t0);
    check("pwrup_sw_level", sw_level, 10'h201);
    check("pwrup_key_level", key_level, 0);
    step(20);
    check("pwrup_sw_hold", sw_level, 10'h201);
    check("queue_drained_b", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/de1_input_conditioner.md
Name: de1_input_conditioner

Overview:
- Conditions the raw DE1-SoC push-buttons (KEY[3:0]) and slide switches (SW[9:0]) before they reach the system's keys/switches PIO exports and the Plasma switch input.
- Per bit: 2-FF synchroniser, then a shared-tick debouncer.
- Produces clean levels plus single-cycle press, release and change pulses.
- Sits directly upstream of the keys/switches PIO exports in the DE1-SoC top level.

Parameters:
- N_KEYS, 4, number of push-buttons.
- N_SW, 10, number of slide switches.
- TICK_CYCLES, 50000, clk_clk cycles per sample tick (1 ms at 50 MHz); must be ≥2.
- STABLE_TICKS, 10, consecutive mismatching ticks needed to accept a new level; must be ≥1.
- KEY_ACTIVE_LOW, 1, raw keys are active-low; key_level outputs are always active-high.

Ports:
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  asynchronous active-low reset.
- key_raw  in  N_KEYS  asynchronous button pins.
- sw_raw  in  N_SW  asynchronous switch pins.
- key_level  out  N_KEYS  debounced pressed state, 1 = pressed.
- key_press  out  N_KEYS  1-cycle pulse on debounced press.
- key_release  out  N_KEYS  1-cycle pulse on debounced release.
- sw_level  out  N_SW  debounced switch state.
- sw_changed  out  N_SW  1-cycle pulse on any debounced switch change.
- init_done  out  1  high once the first debounce window has elapsed.

Behaviour:
- **Clock and reset:** one clock, clk_clk. Reset is asynchronous, active-low, on reset_reset_n.
- **Reset values:**
  - All outputs 0.
  - Synchroniser flops hold the inactive raw level: keys = KEY_ACTIVE_LOW, switches = 0.
  - Prescaler, per-bit counters and init counter = 0.
- **Synchroniser:** 2 flops per bit; keys are inverted after synchronisation when KEY_ACTIVE_LOW=1.
- **Prescaler:**
  - Counts 0..TICK_CYCLES-1 and wraps.
  - sample_tick is high for the single cycle in which the count equals TICK_CYCLES-1.
- **Per-bit debouncer:** state = stable, cnt[$clog2(STABLE_TICKS+1)-1:0].
  - On a tick with sync==stable: cnt←0.
  - On a tick with sync!=stable and cnt<STABLE_TICKS-1: cnt←cnt+1.
  - On a tick with sync!=stable and cnt==STABLE_TICKS-1: stable←sync, cnt←0.
  - No state changes on non-tick cycles.
  - A glitch shorter than STABLE_TICKS ticks never reaches the output.
- **Latency:** a clean edge appears on the level output after 2 sync cycles plus between (STABLE_TICKS-1)·TICK_CYCLES+1 and STABLE_TICKS·TICK_CYCLES cycles.
- **Pulses:**
  - Registered; high in exactly the cycle the level output first shows the new value.
  - key_press = rising edge of key_level; key_release = falling edge; sw_changed = either edge.
  - Never two consecutive cycles.
- **init_done:**
  - Counts STABLE_TICKS ticks after reset, then goes high and stays high until the next reset.
  - While init_done=0, level outputs follow the debouncer normally but all pulses are forced to 0. Switches already on at power-up therefore do not produce sw_changed.
- **Simultaneous events:** bits are independent; several bits may pulse in the same cycle.
- **Reset mid-debounce:** in-flight counts are discarded; init_done drops to 0 immediately.

Optional Feature:
- Macro: INPUT_EDGE_CAPTURE_EN.
- When defined, the block adds:
  - Input edge_clear (N_KEYS, write-one-to-clear).
  - Output edge_capture (N_KEYS): sticky bits set by key_press.
  - Output irq: the OR of edge_capture.
- Same-cycle set and clear of one bit: set wins.
- Reset clears edge_capture.
- When the macro is undefined, these ports and their logic do not exist.

Decomposition:
- Package de1_io_pkg holds:
  - Default constants: CLK_HZ=50_000_000, DEF_TICK_CYCLES, DEF_STABLE_TICKS.
  - A function computing counter width.
- Sub-module debounce_bit: one synchroniser plus one debouncer plus edge detect. Inputs are clk_clk, reset_reset_n, raw, sample_tick, en_pulses and init_level; outputs are level, rise and fall.
- The top level instantiates it N_KEYS+N_SW times via generate and owns the prescaler, init counter and optional capture logic.

Test Plan (bench parameters: TICK_CYCLES=4, STABLE_TICKS=3):
- **Reset state:** hold reset, release with key_raw=4'hF and sw_raw=0 → all outputs 0; init_done rises after 3 ticks (cycle 12 ± sync).
- **Clean press:** key_raw[0]=0 held for 20 cycles after init_done → key_level[0]=1 within 2+12 cycles; one key_press[0] pulse; no key_release.
- **Glitch rejection:** key_raw[1] low for 7 cycles (<3 ticks), then high → key_level[1] stays 0; no pulses.
- **Power-up switch:** sw_raw=10'h201 during and after reset → sw_level=10'h201 by init_done; sw_changed never asserted.
- **Simultaneous edges:** sw[3] toggled and key[2] released in the same cycle → sw_changed[3] and key_release[2] pulse in the same cycle.
- **Edge capture (with INPUT_EDGE_CAPTURE_EN):** press key[3] → edge_capture=4'h8 and irq=1. edge_clear=4'h8 coinciding with a second press pulse → bit stays set. Clear alone → irq=0 the next cycle.
